// File: rtl/heichips25_vga_pattern.sv
// heichips25_vga_pattern: VGA test-pattern source (bars, checker, gradient, solid) on the Tiny VGA PMOD pinout.
// Define VGA_SCROLL_EN to scroll the checker and gradient patterns one pixel left per frame.
`default_nettype none

module heichips25_vga_pattern #(
   parameter int CLK_DIV  = 5,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int SW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SW-1:0] BAR_LAST  = SW'(BAR_W - 1);

   logic [DW-1:0] div;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [SW-1:0] bar_sub;
   logic [2:0]    bar_idx;
   logic          btn_meta, btn_sync, btn_prev;
   logic [1:0]    mode;
   logic [7:0]    offset;
   logic [9:0]    x;
   logic [8:0]    y;
   logic [5:0]    colour;
   logic          pix_en, line_end, frame_end, active, hsync_n, vsync_n;

   assign pix_en    = (div == DIV_LAST) && ena;
   assign line_end  = (hcnt == H_LAST);
   assign frame_end = line_end && (vcnt == V_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (ena) begin
         div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt    <= '0;
         vcnt    <= '0;
         bar_sub <= '0;
         bar_idx <= '0;
      end else if (pix_en) begin
         if (line_end) begin
            hcnt    <= '0;
            vcnt    <= frame_end ? '0 : vcnt + VW'(1);
            bar_sub <= '0;
            bar_idx <= '0;
         end else begin
            hcnt <= hcnt + HW'(1);
            if (bar_sub == BAR_LAST) begin
               bar_sub <= '0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_sub <= bar_sub + SW'(1);
            end
         end
      end
   end

   // Button is sampled once per frame, which both debounces it and keeps a frame single-mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         btn_prev <= 1'b0;
         mode     <= 2'd0;
      end else begin
         btn_meta <= ui_in[0];
         btn_sync <= btn_meta;
         if (pix_en && frame_end) begin
            btn_prev <= btn_sync;
            if (btn_sync && !btn_prev) mode <= mode + 2'd1;
         end
      end
   end

`ifdef VGA_SCROLL_EN
   logic [7:0] frame_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= 8'd0;
      end else if (pix_en && frame_end) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign offset = frame_cnt;
`else
   assign offset = 8'd0;
`endif

   assign x       = 10'(hcnt) + {2'b00, offset};
   assign y       = 9'(vcnt);
   assign active  = (hcnt < H_ACT_END) && (vcnt < V_ACT_END) && !ui_in[1];
   assign hsync_n = !((hcnt >= HS_BEGIN) && (hcnt < HS_END));
   assign vsync_n = !((vcnt >= VS_BEGIN) && (vcnt < VS_END));

   always_comb begin
      colour = 6'd0;
      case (mode)
         2'd0:    colour = {bar_idx[2], bar_idx[2], bar_idx[1], bar_idx[1], bar_idx[0], bar_idx[0]};
         2'd1:    colour = (x[5] ^ y[5]) ? 6'h3F : 6'h00;
         2'd2:    colour = {x[8:7], y[8:7], x[6:5] ^ y[6:5]};
         default: colour = ui_in[7:2];
      endcase
      if (!active) colour = 6'd0;
   end

   // colour is {R1,R0,G1,G0,B1,B0}; the PMOD wants {HS,B0,G0,R0,VS,B1,G1,R1}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_out <= 8'h88;
      end else if (pix_en) begin
         uo_out <= {hsync_n, colour[0], colour[2], colour[4],
                    vsync_n, colour[1], colour[3], colour[5]};
      end
   end

   assign uio_out = {mode, 6'b0};
   assign uio_oe  = 8'hC0;

   logic unused;
   assign unused = &{1'b0, uio_in, x[9], x[4:0], y[4:0]};

endmodule

`default_nettype wire

// File: tb/tb_heichips25_vga_pattern.sv
// tb_heichips25_vga_pattern: randomized bench for heichips25_vga_pattern against a pixel-index reference model.
`default_nettype none

module tb_heichips25_vga_pattern;
   localparam int CLK_DIV  = 2;
   localparam int H_ACTIVE = 48;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 4;
   localparam int H_BP     = 2;
   localparam int V_ACTIVE = 34;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 1;
   localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W    = H_ACTIVE / 8;
   localparam int FRAME    = HT * VT * CLK_DIV;
   localparam int PRESS    = FRAME + FRAME / 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h5A;
   logic [7:0] uo_out, uio_out, uio_oe;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   heichips25_vga_pattern #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected PMOD word for pixel (h,v) straight from the pattern rules.
   function automatic logic [7:0] pixel_word(input int h, input int v, input int m,
                                             input int off, input logic [7:0] ui);
      int x, y;
      logic [2:0] b;
      logic [5:0] c;
      logic hs, vs;
      x = (h + off) % 1024;
      y = v % 512;
      b = 3'(h / BAR_W);
      case (m)
         0:       c = {b[2], b[2], b[1], b[1], b[0], b[0]};
         1:       c = ((((x / 32) ^ (y / 32)) % 2) != 0) ? 6'h3F : 6'h00;
         2:       c = {2'(x / 128), 2'(y / 128), 2'(((x / 32) % 4) ^ ((y / 32) % 4))};
         default: c = ui[7:2];
      endcase
      if (!(h < H_ACTIVE && v < V_ACTIVE && !ui[1])) c = 6'd0;
      hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
      vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
   endfunction

   // Reference: count enabled clocks, derive the pixel index, and step the mode at frame boundaries.
   int         en_clks = 0, pix = 0, m_mode = 0, mh, mv, mf, moff;
   bit         d1 = 0, d2 = 0, bsync, m_prev = 0;
   logic [7:0] exp_uo = 8'h88;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_clks = 0; pix = 0; m_mode = 0; m_prev = 0; d1 = 0; d2 = 0;
         exp_uo = 8'h88;
      end else begin
         bsync = d2; d2 = d1; d1 = ui_in[0];
         if (ena) begin
            en_clks++;
            if (en_clks % CLK_DIV == 0) begin
               mh = pix % HT;
               mv = (pix / HT) % VT;
               mf = pix / (HT * VT);
`ifdef VGA_SCROLL_EN
               moff = mf % 256;
`else
               moff = 0;
`endif
               exp_uo = pixel_word(mh, mv, m_mode, moff, ui_in);
               pix++;
               if (mh == HT - 1 && mv == VT - 1) begin
                  if (bsync && !m_prev) m_mode = (m_mode + 1) % 4;
                  m_prev = bsync;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("uo_out", uo_out, exp_uo);
         check("uio_out", uio_out, {2'(m_mode), 6'b0});
      end
   end

   task automatic run(input int n, input bit rnd);
      repeat (n) begin
         @(negedge clk);
         if (rnd) begin
            ena = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 299) == 0) ui_in[1] = ~ui_in[1];
            if ($urandom_range(0, 199) == 0) ui_in[7:2] = 6'($urandom);
         end
      end
      @(negedge clk);
      ena = 1'b1;
   endtask

   task automatic press();
      ui_in[0] = 1'b1;
      run(PRESS, 1'b1);
      ui_in[0] = 1'b0;
      run(PRESS, 1'b1);
   endtask

   initial begin
      int n;
      repeat (4) @(negedge clk);
      check("rst_uo", uo_out, 8'h88);
      check("rst_uio", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'hC0);
      chk_on = 1'b1;
      ui_in = {6'b110000, 2'b00};

      // First hsync falling edge after release, counted in clocks.
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (uo_out[7] !== 1'b0 && n <= 3 * HT * CLK_DIV) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("hs_first_fall", n, (H_ACTIVE + H_FP + 1) * CLK_DIV);

      run(FRAME, 1'b1);
      repeat (4) press();
      check("mode_wrap", uio_out[7:6], 2'd0);

      // Into mode 1, then reset part-way through a frame.
      ui_in[0] = 1'b1;
      run(PRESS, 1'b1);
      ui_in[0] = 1'b0;
      run(FRAME / 2 + 37, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_uo", uo_out, 8'h88);
      check("rst_async_uio", uio_out, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ui_in[1] = 1'b0;
      run(FRAME + FRAME / 2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
